// File: rtl/booth_seq_mult.sv
// rtl/booth_seq_mult.sv - sequential radix-4 Booth multiplier, one digit per clock
//
// Purpose: multiplies coefficient ia by sample ib for the FIR tap datapath.
// A start/done handshake connects the fetch stage upstream to the tap
// accumulator downstream. A step counter walks the Booth digits, one per
// clock, through a single digit adder.
//
// Optional feature macro: BOOTH_UNSIGNED_EN
//   defined   - operands are unsigned; one extra digit, odone one cycle later
//   undefined - operands are two's complement (default)
//
// Ports:
//   iclk    in   1          system clock, rising edge
//   irst_n  in   1          asynchronous active-low reset
//   istart  in   1          start request, sampled only in IDLE
//   ia      in   WIDTH      multiplicand (coefficient)
//   ib      in   WIDTH      multiplier (sample)
//   obusy   out  1          high in RUN and DONE
//   odone   out  1          one-cycle pulse, oprod valid while high
//   oprod   out  2*WIDTH    registered product, held until next completion
//   ocnt    out  CW         current digit index

module booth_seq_mult #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH/2+2)
) (
    input  logic                 iclk,
    input  logic                 irst_n,
    input  logic                 istart,
    input  logic [WIDTH-1:0]     ia,
    input  logic [WIDTH-1:0]     ib,
    output logic                 obusy,
    output logic                 odone,
    output logic [2*WIDTH-1:0]   oprod,
    output logic [CW-1:0]        ocnt
);

    localparam int PW = 2*WIDTH;
`ifdef BOOTH_UNSIGNED_EN
    // Zero-extending B by two bits adds a top digit {0,0,B[WIDTH-1]}.
    localparam int NDIG = WIDTH/2 + 1;
`else
    localparam int NDIG = WIDTH/2;
`endif
    localparam logic [CW-1:0] LAST_IDX = CW'(NDIG-1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    // r_a is the multiplicand pre-shifted by 2i, so each digit only needs
    // 0, +-A or +-2A of the current register value.
    logic [PW-1:0]      r_a;
    logic [PW-1:0]      r_acc;
    logic [PW-1:0]      r_prod;
    // r_b shifts right two bits per digit; r_bm1 carries B[2i-1].
    logic [WIDTH-1:0]   r_b;
    logic               r_bm1;
    logic [CW-1:0]      r_cnt;

    logic [PW-1:0]      w_a_ext;
    logic [2:0]         w_trip;
    logic [PW-1:0]      w_term;
    logic [PW-1:0]      w_acc_nxt;
    logic               w_last;

`ifdef BOOTH_UNSIGNED_EN
    assign w_a_ext = {{WIDTH{1'b0}}, ia};
`else
    assign w_a_ext = {{WIDTH{ia[WIDTH-1]}}, ia};
`endif

    assign w_trip    = {r_b[1], r_b[0], r_bm1};
    assign w_last    = (r_cnt == LAST_IDX);
    assign w_acc_nxt = r_acc + w_term;

    always_comb begin
        w_term = '0;
        case (w_trip)
            3'b001, 3'b010: w_term = r_a;
            3'b011:         w_term = r_a << 1;
            3'b100:         w_term = -(r_a << 1);
            3'b101, 3'b110: w_term = -r_a;
            default:        w_term = '0;
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        obusy       = 1'b0;
        odone       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (istart) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                obusy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                obusy       = 1'b1;
                odone       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_bm1  <= 1'b0;
            r_acc  <= '0;
            r_prod <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (istart) begin
                        r_a   <= w_a_ext;
                        r_b   <= ib;
                        r_bm1 <= 1'b0;
                        r_acc <= '0;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_a   <= r_a << 2;
                    r_b   <= r_b >> 2;
                    r_bm1 <= r_b[1];
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_prod <= w_acc_nxt;
                    end
                end
                S_DONE: begin
                    // DONE always returns to IDLE, where the count reads 0.
                    r_cnt <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign oprod = r_prod;
    assign ocnt  = r_cnt;

endmodule
